// File: rtl/rtc_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rtc_read_sequencer
// Purpose  : Reads eleven RTC registers (8'h21..8'h28, 8'h41..8'h43) over a
//            multiplexed address/data bus. A sweep starts on a start pulse or
//            on a periodic refresh tick. Each register takes an address phase,
//            a gap, a read phase, a one-cycle capture and a second gap. The
//            captured byte appears on data_vga together with its address on
//            the capture cycle.
// Ports    : clk      - system clock, rising edge
//            reset    - asynchronous reset, active low
//            start    - single-cycle sweep request (ignored while busy)
//            ad_in    - RTC bus, read path
//            ad_out   - RTC bus, drive path (valid while ad_oe=1)
//            ad_oe    - bus output enable
//            cs_n     - chip select, active low
//            rd_n     - read strobe, active low
//            wr_n     - write (address latch) strobe, active low
//            a_d      - 0 = address phase, 1 = data phase
//            address  - register-bank address, 8'h00 except on capture cycles
//            data_vga - captured RTC byte, valid when address != 8'h00
//            busy     - sweep in progress
//            done     - one-cycle pulse on the first idle cycle after a sweep
// Revision : 1.0 - initial release
// ============================================================================
module rtc_read_sequencer #(
    parameter int T_PHASE = 10,       // cycles per bus phase, 2..255
    parameter int REFRESH = 1000000   // cycles between automatic sweeps
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic [7:0] address,
    output logic [7:0] data_vga,
    output logic       busy,
    output logic       done
);

    localparam int             RW        = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam logic [RW-1:0]  REF_LAST  = RW'(REFRESH - 1);
    localparam logic [7:0]     PH_LAST   = 8'(T_PHASE - 1);
    localparam logic [3:0]     IDX_LAST  = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_GAP1 = 3'd2,
        S_DATA = 3'd3,
        S_CAPT = 3'd4,
        S_GAP2 = 3'd5
    } state_t;

    state_t        state_q;
    logic [7:0]    phase_q;
    logic [3:0]    idx_q;
    logic [RW-1:0] refresh_q;
    logic [RW-1:0] refresh_d;
    logic [7:0]    ad_out_q;
    logic          ad_oe_q;
    logic          cs_n_q;
    logic          rd_n_q;
    logic          wr_n_q;
    logic          a_d_q;
    logic [7:0]    address_q;
    logic [7:0]    data_vga_q;
    logic          busy_q;
    logic          done_q;

    logic          refresh_tick;
    logic          phase_last;
    logic [7:0]    cur_addr;
    logic [7:0]    next_addr;

    // Index 0..7 maps to 8'h21..8'h28, index 8..10 to 8'h41..8'h43.
    function automatic logic [7:0] rtc_addr(input logic [3:0] idx);
        if (idx < 4'd8) begin
            return 8'h21 + {4'd0, idx};
        end
        return 8'h39 + {4'd0, idx};
    endfunction

    always_comb begin
        refresh_tick = (refresh_q == REF_LAST);
        refresh_d    = refresh_tick ? '0 : refresh_q + RW'(1);
        phase_last   = (phase_q == PH_LAST);
        cur_addr     = rtc_addr(idx_q);
        next_addr    = rtc_addr(idx_q + 4'd1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            idx_q      <= '0;
            refresh_q  <= '0;
            ad_out_q   <= 8'h00;
            ad_oe_q    <= 1'b0;
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            a_d_q      <= 1'b0;
            address_q  <= 8'h00;
            data_vga_q <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            refresh_q <= refresh_d;
            done_q    <= 1'b0;
            address_q <= 8'h00;
            // Phase counter restarts at every phase boundary; IDLE and the
            // single-cycle capture keep it parked at zero.
            phase_q   <= (phase_last || state_q == S_IDLE || state_q == S_CAPT)
                         ? 8'd0 : phase_q + 8'd1;

            case (state_q)
                S_IDLE: begin
                    // start and tick together still launch a single sweep.
                    if (start || refresh_tick) begin
                        state_q  <= S_ADDR;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        cs_n_q   <= 1'b0;
                        wr_n_q   <= 1'b0;
                        rd_n_q   <= 1'b1;
                        a_d_q    <= 1'b0;
                        ad_oe_q  <= 1'b1;
                        ad_out_q <= rtc_addr(4'd0);
                    end
                end
                S_ADDR: begin
                    if (phase_last) begin
                        state_q  <= S_GAP1;
                        cs_n_q   <= 1'b1;
                        wr_n_q   <= 1'b1;
                        ad_oe_q  <= 1'b0;
                        ad_out_q <= 8'h00;
                    end
                end
                S_GAP1: begin
                    // Bus is released a full phase before the read strobe,
                    // so ad_oe and rd_n can never overlap.
                    if (phase_last) begin
                        state_q <= S_DATA;
                        cs_n_q  <= 1'b0;
                        rd_n_q  <= 1'b0;
                        a_d_q   <= 1'b1;
                    end
                end
                S_DATA: begin
                    // Sample only at the end of the read phase, when the
                    // RTC output has had the whole phase to settle.
                    if (phase_last) begin
                        state_q    <= S_CAPT;
                        cs_n_q     <= 1'b1;
                        rd_n_q     <= 1'b1;
                        data_vga_q <= ad_in;
                        address_q  <= cur_addr;
                    end
                end
                S_CAPT: begin
                    state_q <= S_GAP2;
                end
                S_GAP2: begin
                    if (phase_last) begin
                        if (idx_q == IDX_LAST) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= S_ADDR;
                            idx_q    <= idx_q + 4'd1;
                            cs_n_q   <= 1'b0;
                            wr_n_q   <= 1'b0;
                            a_d_q    <= 1'b0;
                            ad_oe_q  <= 1'b1;
                            ad_out_q <= next_addr;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ad_out   = ad_out_q;
    assign ad_oe    = ad_oe_q;
    assign cs_n     = cs_n_q;
    assign rd_n     = rd_n_q;
    assign wr_n     = wr_n_q;
    assign a_d      = a_d_q;
    assign address  = address_q;
    assign data_vga = data_vga_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_read_sequencer
// Purpose  : Self-checking bench for rtc_read_sequencer. An RTC bus model
//            returns 8'hA0+index only on the last read cycle and pushes the
//            expected capture to a scoreboard; captures are popped and
//            compared. A cycle-level timing model checks strobes, busy/done
//            and address each cycle. A second instance with REFRESH=600
//            checks automatic sweeps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_read_sequencer;

    localparam int TP    = 10;
    localparam int REG_T = 4 * TP + 1;
    localparam int SWEEP = 11 * REG_T;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe, cs_n, rd_n, wr_n, a_d, busy, done;
    logic [7:0] address, data_vga;

    logic       rst_r, start_r;
    logic [7:0] ad_in_r;
    logic [7:0] ad_out_r, address_r, data_vga_r;
    logic       ad_oe_r, cs_n_r, rd_n_r, wr_n_r, a_d_r, busy_r, done_r;

    int n_chk  = 0;
    int n_fail = 0;
    int n_capt = 0;

    logic [15:0] sb_q[$];
    logic [15:0] sb_e;
    logic [7:0]  addr_lat;
    int          run = 0;
    int          cs_hi_run = 0;
    bit          seen_txn = 1'b0;

    always #5 clk = ~clk;

    rtc_read_sequencer #(.T_PHASE(TP), .REFRESH(1000000)) dut (
        .clk(clk), .reset(reset), .start(start), .ad_in(ad_in),
        .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .a_d(a_d), .address(address), .data_vga(data_vga),
        .busy(busy), .done(done)
    );

    rtc_read_sequencer #(.T_PHASE(TP), .REFRESH(600)) dut_r (
        .clk(clk), .reset(rst_r), .start(start_r), .ad_in(ad_in_r),
        .ad_out(ad_out_r), .ad_oe(ad_oe_r), .cs_n(cs_n_r), .rd_n(rd_n_r),
        .wr_n(wr_n_r), .a_d(a_d_r), .address(address_r), .data_vga(data_vga_r),
        .busy(busy_r), .done(done_r)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_addr(input int k);
        if (k < 8) return 8'(8'h21 + k);
        return 8'(8'h41 + k - 8);
    endfunction

    function automatic int addr_idx(input logic [7:0] a);
        if (a >= 8'h41) return int'(a) - 'h41 + 8;
        return int'(a) - 'h21;
    endfunction

    // RTC model: garbage on ad_in except on the last read cycle.
    always @(negedge clk) begin
        if (!cs_n && !wr_n && ad_oe) addr_lat = ad_out;
        if (!rd_n) run++;
        else run = 0;
        if (run == TP) begin
            ad_in = 8'(8'hA0 + addr_idx(addr_lat));
            sb_q.push_back({addr_lat, ad_in});
        end else begin
            ad_in = 8'h3C ^ 8'(run);
        end
    end

    // Scoreboard and bus rules.
    always @(negedge clk) begin
        if (address != 8'h00) begin
            n_capt++;
            if (sb_q.size() == 0) begin
                check("capt_unexpected", {16'h0, address, data_vga}, 32'h0);
            end else begin
                sb_e = sb_q.pop_front();
                check("capture", {16'h0, address, data_vga}, {16'h0, sb_e});
            end
        end
        check("bus_oe_rd", 32'(ad_oe & ~rd_n), 32'h0);
        if (!reset) begin
            cs_hi_run = 0;
            seen_txn  = 1'b0;
        end else if (cs_n) begin
            cs_hi_run++;
        end else begin
            if (cs_hi_run > 0 && seen_txn) check("cs_gap", 32'(cs_hi_run >= TP), 32'h1);
            if (cs_hi_run > 0) seen_txn = 1'b1;
            cs_hi_run = 0;
        end
    end

    // Start pulse in cycle 0, then check cycles 1..last_c against the
    // timing model. Extra start pulses at cycles 5 and 200 when asked.
    task automatic run_sweep(input int last_c, input bit extra);
        int n_done;
        int k, r;
        logic [5:0] ec;
        logic [7:0] ea;
        n_done = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            start = extra && (c == 5 || c == 200);
            ea = 8'h00;
            if (c <= SWEEP) begin
                k = (c - 1) / REG_T;
                r = (c - 1) % REG_T;
                if (r < TP) begin
                    ec = 6'b010110;
                    check($sformatf("ad_out@%0d", c), 32'(ad_out), 32'(exp_addr(k)));
                    check($sformatf("a_d@%0d", c), 32'(a_d), 32'h0);
                end else if (r < 2 * TP) begin
                    ec = 6'b111010;
                    check($sformatf("a_d@%0d", c), 32'(a_d), 32'h0);
                end else if (r < 3 * TP) begin
                    ec = 6'b001010;
                    check($sformatf("a_d@%0d", c), 32'(a_d), 32'h1);
                end else if (r == 3 * TP) begin
                    ec = 6'b111010;
                    ea = exp_addr(k);
                end else begin
                    ec = 6'b111010;
                    check($sformatf("a_d@%0d", c), 32'(a_d), 32'h1);
                end
            end else if (c == SWEEP + 1) begin
                ec = 6'b111001;
            end else begin
                ec = 6'b111000;
            end
            check($sformatf("ctrl@%0d", c), {26'h0, cs_n, rd_n, wr_n, ad_oe, busy, done}, {26'h0, ec});
            check($sformatf("address@%0d", c), 32'(address), 32'(ea));
            if (done) n_done++;
        end
        start = 1'b0;
        if (last_c > SWEEP) check("done_count", n_done, 1);
    endtask

    initial begin
        int capt0;
        int nr, nd;
        int rises[4];
        bit prev;

        reset   = 1'b0;
        start   = 1'b0;
        rst_r   = 1'b0;
        start_r = 1'b0;
        ad_in_r = 8'h00;

        repeat (3) @(negedge clk);
        check("reset_ctrl", {25'h0, cs_n, rd_n, wr_n, ad_oe, a_d, busy, done}, 32'b1110000);
        check("reset_bus", {8'h0, ad_out, address, data_vga}, 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Full sweep with ignored extra start pulses.
        run_sweep(SWEEP + 8, 1'b1);
        check("sb_drained", sb_q.size(), 0);

        // Abort during the read phase of index 4 (cycle 190).
        capt0 = n_capt;
        run_sweep(190, 1'b0);
        reset = 1'b0;
        #1;
        check("abort_ctrl", {25'h0, cs_n, rd_n, wr_n, ad_oe, a_d, busy, done}, 32'b1110000);
        check("abort_bus", {8'h0, ad_out, address, data_vga}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_idle", {30'h0, busy, cs_n}, 32'h1);
        check("abort_captures", n_capt - capt0, 4);
        check("abort_sb_empty", sb_q.size(), 0);
        run_sweep(SWEEP + 8, 1'b0);

        // Refresh ticks on the REFRESH=600 instance.
        @(negedge clk);
        rst_r = 1'b1;
        nr = 0;
        nd = 0;
        prev = 1'b0;
        for (int i = 0; i < 4; i++) rises[i] = 0;
        for (int c = 1; c <= 2300; c++) begin
            @(negedge clk);
            start_r = (c == 1799);
            if (busy_r && !prev) begin
                if (nr < 4) rises[nr] = c;
                nr++;
            end
            prev = busy_r;
            if (done_r) nd++;
        end
        start_r = 1'b0;
        check("refresh_sweeps", nr, 3);
        check("refresh_rise0", rises[0], 600);
        check("refresh_rise1", rises[1], 1200);
        check("refresh_rise2", rises[2], 1800);
        check("refresh_dones", nd, 3);
        check("refresh_idle", 32'(busy_r), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
